// File: rtl/mlp_classifier.sv
// mlp_classifier
// Fixed-weight two-layer integer perceptron. Seven 4-bit unsigned features
// feed three ReLU hidden neurons and three linear output neurons. The index
// of the largest output neuron (lowest index wins ties) is registered once.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   synchronous active-low reset
//   in_valid  in   1   inp carries a sample to classify this cycle
//   inp       in   28  packed features, x_i = inp[4i+3:4i], i = 0..6
//   out       out  2   registered class index, 0..2
//   out_valid out  1   out was updated on the last edge
module mlp_classifier #(
  parameter int NUM_A    = 7,
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [NUM_A*WIDTH_A-1:0]   inp,
  output logic [OUTWIDTH-1:0]        out,
  output logic                       out_valid
);

  // Clamp a hidden-layer accumulator to the 8-bit unsigned range.
  // Negative values are the ReLU zero; values above 255 cannot occur with
  // these weights, but saturating keeps every accumulator bit meaningful.
  function automatic logic [7:0] relu8(input logic signed [10:0] v);
    logic [7:0] r;
    if (v[10]) begin
      r = 8'd0;
    end else if (|v[9:8]) begin
      r = 8'hFF;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  logic signed [10:0] x_s [7];
  logic signed [10:0] acc0_s, acc1_s, acc2_s;
  logic        [7:0]  h0_s, h1_s, h2_s;
  logic signed [11:0] hw0_s, hw1_s, hw2_s;
  logic signed [11:0] o0_s, o1_s, o2_s;
  logic        [OUTWIDTH-1:0] class_s;
  logic        [OUTWIDTH-1:0] out_r;
  logic                       out_valid_r;

  // Zero-extend each 4-bit feature into a signed accumulator-width operand.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      x_s[i] = {7'd0, inp[WIDTH_A*i +: WIDTH_A]};
    end
  end

  // Hidden layer: constant weights realised as shifts and adds.
  always_comb begin
    // W1[0] = ( 2, -1,  0,  3, -2,  1,  0), b = -4
    acc0_s = (x_s[0] <<< 1) - x_s[1] + ((x_s[3] <<< 1) + x_s[3])
           - (x_s[4] <<< 1) + x_s[5] - 11'sd4;
    // W1[1] = (-1,  2,  1,  0,  1, -3,  2), b = +2
    acc1_s = (x_s[1] <<< 1) - x_s[0] + x_s[2] + x_s[4]
           - ((x_s[5] <<< 1) + x_s[5]) + (x_s[6] <<< 1) + 11'sd2;
    // W1[2] = ( 0,  1, -2,  1,  3,  0, -1), b = -1
    acc2_s = x_s[1] - (x_s[2] <<< 1) + x_s[3]
           + ((x_s[4] <<< 1) + x_s[4]) - x_s[6] - 11'sd1;
    h0_s = relu8(acc0_s);
    h1_s = relu8(acc1_s);
    h2_s = relu8(acc2_s);
  end

  // Output layer: linear combination of hidden activations, no activation.
  always_comb begin
    hw0_s = {4'd0, h0_s};
    hw1_s = {4'd0, h1_s};
    hw2_s = {4'd0, h2_s};
    o0_s  = hw0_s - hw1_s + (hw2_s <<< 1);
    o1_s  = (hw1_s <<< 1) - hw0_s - hw2_s + 12'sd5;
    o2_s  = hw0_s + hw1_s - (hw2_s <<< 1) - 12'sd3;
  end

  // Argmax with ties going to the lower index; index 3 is never produced.
  always_comb begin
    if ((o0_s >= o1_s) && (o0_s >= o2_s)) begin
      class_s = 2'd0;
    end else if (o1_s >= o2_s) begin
      class_s = 2'd1;
    end else begin
      class_s = 2'd2;
    end
  end

  // Result register: capture the class on valid samples, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_r       <= 2'd0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      out_r       <= class_s;
      out_valid_r <= 1'b1;
    end else begin
      out_r       <= out_r;
      out_valid_r <= 1'b0;
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mlp_classifier.sv
// Self-checking bench for mlp_classifier: directed vectors with hand-computed
// classes, streaming, hold behaviour, tie cases, reset, plus a random sweep
// against an independent integer model of the network.
module tb_mlp_classifier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [27:0] inp;
  logic [1:0]  out;
  logic        out_valid;

  int n_asserts;
  int n_fail;

  mlp_classifier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inp       (inp),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference network using plain integer multiplication.
  function automatic int model(input logic [27:0] v);
    int w1 [3][7];
    int b1 [3];
    int x [7];
    int h [3];
    int o [3];
    int best;
    w1[0] = '{ 2, -1,  0,  3, -2,  1,  0};
    w1[1] = '{-1,  2,  1,  0,  1, -3,  2};
    w1[2] = '{ 0,  1, -2,  1,  3,  0, -1};
    b1    = '{-4, 2, -1};
    for (int i = 0; i < 7; i++) x[i] = int'(v[4*i +: 4]);
    for (int j = 0; j < 3; j++) begin
      h[j] = b1[j];
      for (int i = 0; i < 7; i++) h[j] = h[j] + w1[j][i] * x[i];
      if (h[j] < 0) h[j] = 0;
    end
    o[0] = h[0] - h[1] + 2 * h[2];
    o[1] = -h[0] + 2 * h[1] - h[2] + 5;
    o[2] = h[0] + h[1] - 2 * h[2] - 3;
    best = 0;
    for (int k = 1; k < 3; k++) if (o[k] > o[best]) best = k;
    return best;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present inputs away from the edge, then sample 1 time unit after it.
  task automatic step(input logic r, input logic v, input logic [27:0] d);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    inp      = d;
    @(posedge clk);
    #1;
  endtask

  localparam logic [27:0] V_ZERO = 28'h0000000;
  localparam logic [27:0] V_ALL  = 28'hFFFFFFF;
  localparam logic [27:0] V_X1   = 28'h00000F0;
  localparam logic [27:0] V_X0X6 = 28'hF00000F;
  localparam logic [27:0] V_T01  = 28'h0301010; // h=(1,0,1) o=(3,3,-4)
  localparam logic [27:0] V_T12  = 28'h0000705; // h=(6,4,0) o=(2,7,7)

  initial begin
    logic [27:0] r_d;
    logic        r_v;
    logic [1:0]  exp_out;
    n_asserts = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    inp       = V_ALL;

    // Reset overrides a valid sample.
    step(1'b0, 1'b1, V_ALL);
    step(1'b0, 1'b1, V_ALL);
    chk("reset_out",   {2'b0, out},       4'd0);
    chk("reset_valid", {3'b0, out_valid}, 4'd0);

    // First sample after release appears one cycle later.
    step(1'b1, 1'b1, V_ALL);
    chk("rel_out",   {2'b0, out},       4'd0);
    chk("rel_valid", {3'b0, out_valid}, 4'd1);

    // Directed vectors, each separated by an idle cycle.
    step(1'b1, 1'b0, V_ZERO);
    chk("idle_valid", {3'b0, out_valid}, 4'd0);
    step(1'b1, 1'b1, V_ZERO);
    chk("zero_out", {2'b0, out}, 4'd1);
    step(1'b1, 1'b1, V_X1);
    chk("x1_out", {2'b0, out}, 4'd1);
    step(1'b1, 1'b1, V_X0X6);
    chk("x0x6_out", {2'b0, out}, 4'd2);

    // Streaming: four samples back to back.
    step(1'b1, 1'b1, V_ALL);
    chk("s0_out", {2'b0, out}, 4'd0);
    chk("s0_vld", {3'b0, out_valid}, 4'd1);
    step(1'b1, 1'b1, V_ZERO);
    chk("s1_out", {2'b0, out}, 4'd1);
    chk("s1_vld", {3'b0, out_valid}, 4'd1);
    step(1'b1, 1'b1, V_ALL);
    chk("s2_out", {2'b0, out}, 4'd0);
    chk("s2_vld", {3'b0, out_valid}, 4'd1);
    step(1'b1, 1'b1, V_X0X6);
    chk("s3_out", {2'b0, out}, 4'd2);
    chk("s3_vld", {3'b0, out_valid}, 4'd1);

    // Drop in_valid and change inp: output holds.
    step(1'b1, 1'b0, V_ZERO);
    chk("hold_out",   {2'b0, out},       4'd2);
    chk("hold_valid", {3'b0, out_valid}, 4'd0);
    step(1'b1, 1'b0, V_X1);
    chk("hold2_out", {2'b0, out}, 4'd2);

    // Ties go to the lower index.
    step(1'b1, 1'b1, V_T01);
    chk("tie01_out", {2'b0, out}, 4'd0);
    step(1'b1, 1'b1, V_X0X6);
    chk("pre_t12_out", {2'b0, out}, 4'd2);
    step(1'b1, 1'b1, V_T12);
    chk("tie12_out", {2'b0, out}, 4'd1);

    // Mid-stream reset discards the in-flight sample and clears out.
    step(1'b1, 1'b1, V_X0X6);
    chk("pre_rst_out", {2'b0, out}, 4'd2);
    step(1'b0, 1'b1, V_X0X6);
    chk("mid_rst_out", {2'b0, out},       4'd0);
    chk("mid_rst_vld", {3'b0, out_valid}, 4'd0);
    step(1'b1, 1'b0, V_X0X6);
    chk("post_rst_out", {2'b0, out},       4'd0);
    chk("post_rst_vld", {3'b0, out_valid}, 4'd0);
    step(1'b1, 1'b1, V_X0X6);
    chk("post_rst_smp", {2'b0, out}, 4'd2);

    // Random sweep against the reference model.
    exp_out = out;
    for (int n = 0; n < 3000; n++) begin
      r_d = 28'($urandom);
      r_v = ($urandom_range(0, 3) != 0);
      step(1'b1, r_v, r_d);
      if (r_v) exp_out = 2'(model(r_d));
      chk("rand_out", {2'b0, out},       {2'b0, exp_out});
      chk("rand_vld", {3'b0, out_valid}, {3'b0, r_v});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
